dbp_block_buffer_pp: RTL and testbench

Decoder-side assembly buffer that collects one base word and up to NUM_DBP delta-bitplanes into a complete DBP block, then presents it downstream through a valid/ready handshake. It is the parametrised, double-buffered successor of the single-bank block buffer. Two ping-pong banks let the next block fill while the previous one waits on a stalled consumer. It adds per-block plane counting, zero-fill of missing planes, and sticky protocol-error detection. It sits between the bitplane decoder and the ZRLE/delta reconstruction stage.

---
 rtl/dbp_block_buffer_pp.sv | 160 ++++++++++++++++
 tb/tb_dbp_block_buffer_pp.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbp_block_buffer_pp.sv
// Double-buffered DBP block assembly buffer: one bank fills from the bitplane
// decoder while the other holds a completed block for the reconstruction stage.
module dbp_block_buffer_pp #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int NUM_DBP    = DATA_W + 1,
    localparam int PLANE_W   = BLOCK_SIZE - 1,
    localparam int DBP_W     = NUM_DBP * PLANE_W,
    localparam int CNT_W     = $clog2(NUM_DBP + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              push_i,
    input  logic              last_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] base_o,
    output logic [DBP_W-1:0]  dbp_o,
    output logic [CNT_W-1:0]  nplanes_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              err_o
);

    typedef enum logic [1:0] {FREE, WAIT_BASE, FILLING, FULL} bank_state_e;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wr_ptr, wr_ptr_d;
    logic              rd_ptr, rd_ptr_d;
    logic [DATA_W-1:0] base_q  [2];
    logic [DBP_W-1:0]  planes_q[2];
    logic [CNT_W-1:0]  count_q [2];
    logic              err_q;
    logic              load_base;
    logic              shift_in;
    logic              err_set;
    logic              release_rd;
    logic [PLANE_W-1:0] new_plane;

    assign new_plane  = data_i[DATA_W-1 -: PLANE_W];
    assign rdy_o      = (state_q[wr_ptr] != FULL);
    assign vld_o      = (state_q[rd_ptr] == FULL);
    assign release_rd = vld_o & rdy_i;

    assign base_o    = base_q[rd_ptr];
    assign dbp_o     = planes_q[rd_ptr];
    assign nplanes_o = count_q[rd_ptr];
    assign err_o     = err_q;

    // The write bank is never FULL while accepting and the read bank is always FULL
    // when released, so the two updates below never touch the same bank.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wr_ptr_d   = wr_ptr;
        rd_ptr_d   = rd_ptr;
        load_base  = 1'b0;
        shift_in   = 1'b0;
        err_set    = 1'b0;

        if (rdy_o) begin
            case (state_q[wr_ptr])
                FREE, WAIT_BASE: begin
                    state_d[wr_ptr] = WAIT_BASE;
                    if (push_i) begin
                        load_base       = 1'b1;
                        state_d[wr_ptr] = FILLING;
                    end else if (last_i) begin
                        err_set = 1'b1;
                    end
                    if (push_i && last_i) begin
                        state_d[wr_ptr] = FULL;
                        wr_ptr_d        = ~wr_ptr;
                    end
                end
                FILLING: begin
                    if (push_i) begin
                        if (count_q[wr_ptr] == CNT_W'(NUM_DBP)) begin
                            err_set = 1'b1;
                        end else begin
                            shift_in = 1'b1;
                        end
                    end
                    if (last_i) begin
                        state_d[wr_ptr] = FULL;
                        wr_ptr_d        = ~wr_ptr;
                    end
                end
                default: ;
            endcase
        end

        if (release_rd) begin
            state_d[rd_ptr] = FREE;
            rd_ptr_d        = ~rd_ptr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q[0] <= FREE;
            state_q[1] <= FREE;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            err_q      <= 1'b0;
        end else if (clr_i) begin
            state_q[0] <= FREE;
            state_q[1] <= FREE;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Banks are zeroed on release so a new block starts with all planes at zero,
    // which gives zero-fill of unpushed low planes for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                base_q[b]   <= '0;
                planes_q[b] <= '0;
                count_q[b]  <= '0;
            end
        end else if (clr_i) begin
            for (int b = 0; b < 2; b++) begin
                base_q[b]   <= '0;
                planes_q[b] <= '0;
                count_q[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (release_rd && (rd_ptr == 1'(b))) begin
                    base_q[b]   <= '0;
                    planes_q[b] <= '0;
                    count_q[b]  <= '0;
                end else if (wr_ptr == 1'(b)) begin
                    if (load_base) begin
                        base_q[b]  <= data_i;
                        count_q[b] <= '0;
                    end
                    if (shift_in) begin
                        planes_q[b] <= {new_plane, planes_q[b][DBP_W-1:PLANE_W]};
                        count_q[b]  <= count_q[b] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dbp_block_buffer_pp.sv
// Self-checking bench for dbp_block_buffer_pp: directed scenarios plus random
// traffic compared against a block-level queue model.
module tb_dbp_block_buffer_pp;

    localparam int DATA_W  = 8;
    localparam int NUM_DBP = 9;
    localparam int PLANE_W = 7;
    localparam int DBP_W   = NUM_DBP * PLANE_W;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic [DATA_W-1:0] data;
    logic              push;
    logic              last;
    logic              in_ready;
    logic [DATA_W-1:0] out_base;
    logic [DBP_W-1:0]  out_dbp;
    logic [CNT_W-1:0]  out_nplanes;
    logic              out_valid;
    logic              ds_ready;
    logic              error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DATA_W-1:0] base;
        logic [DBP_W-1:0]  dbp;
        logic [CNT_W-1:0]  n;
    } blk_t;

    blk_t              out_q[$];
    logic              cur_active;
    logic [DATA_W-1:0] cur_base;
    logic [PLANE_W-1:0] cur_planes[$];
    logic              m_err;

    dbp_block_buffer_pp dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (clr),
        .data_i   (data),
        .push_i   (push),
        .last_i   (last),
        .rdy_o    (in_ready),
        .base_o   (out_base),
        .dbp_o    (out_dbp),
        .nplanes_o(out_nplanes),
        .vld_o    (out_valid),
        .rdy_i    (ds_ready),
        .err_o    (error)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        out_q.delete();
        cur_planes.delete();
        cur_active = 1'b0;
        cur_base   = '0;
        m_err      = 1'b0;
    endfunction

    // The i-th of n pushed planes lands at index NUM_DBP-n+i; everything below is zero.
    function automatic void model_complete();
        blk_t b;
        int   n;
        n      = cur_planes.size();
        b.base = cur_base;
        b.dbp  = '0;
        b.n    = CNT_W'(n);
        for (int i = 0; i < n; i++) begin
            b.dbp[(NUM_DBP - n + i) * PLANE_W +: PLANE_W] = cur_planes[i];
        end
        out_q.push_back(b);
        cur_active = 1'b0;
        cur_planes.delete();
    endfunction

    task automatic tick(input logic p, input logic l, input logic c,
                        input logic [DATA_W-1:0] d, input logic r);
        bit acc;
        bit rel;
        push     = p;
        last     = l;
        clr      = c;
        data     = d;
        ds_ready = r;
        acc = (out_q.size() < 2);
        rel = (out_q.size() > 0) && r;
        if (c) begin
            model_clear();
        end else begin
            if (rel) void'(out_q.pop_front());
            if (acc) begin
                if (!cur_active) begin
                    if (p) begin
                        cur_base   = d;
                        cur_planes.delete();
                        cur_active = 1'b1;
                        if (l) model_complete();
                    end else if (l) begin
                        m_err = 1'b1;
                    end
                end else begin
                    if (p) begin
                        if (cur_planes.size() == NUM_DBP) m_err = 1'b1;
                        else cur_planes.push_back(d[DATA_W-1:1]);
                    end
                    if (l) model_complete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        clr      = 1'b0;
        push     = 1'b0;
        last     = 1'b0;
        data     = '0;
        ds_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, in_ready, error} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: vld/rdy/err got %b%b%b want 010", out_valid, in_ready, error);
        end
        checks++;
        if ({out_base, out_dbp, out_nplanes} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: base %h dbp %h n %0d want all zero", out_base, out_dbp, out_nplanes);
        end
    endtask

    task automatic test_single_block();
        tick(1'b1, 1'b0, 1'b0, 8'hA5, 1'b1);
        for (int i = 1; i <= 9; i++) tick(1'b1, i == 9, 1'b0, {7'(i), 1'b0}, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_base !== 8'hA5 || out_nplanes !== 4'd9 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_hdr: vld %b base %h n %0d err %b want 1 a5 9 0", out_valid, out_base, out_nplanes, error);
        end
        checks++;
        if (out_dbp[8*PLANE_W +: PLANE_W] !== 7'h09 || out_dbp[0 +: PLANE_W] !== 7'h01) begin
            errors++;
            $display("[TB] FAIL single_planes: p8 %h p0 %h want 09 01", out_dbp[8*PLANE_W +: PLANE_W], out_dbp[0 +: PLANE_W]);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: vld got %b want 0", out_valid);
        end
    endtask

    task automatic test_short_block();
        tick(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'h54, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_base !== 8'h10 || out_nplanes !== 4'd3) begin
            errors++;
            $display("[TB] FAIL short_hdr: vld %b base %h n %0d want 1 10 3", out_valid, out_base, out_nplanes);
        end
        checks++;
        if (out_dbp[8*PLANE_W +: PLANE_W] !== 7'h2A || out_dbp[7*PLANE_W +: PLANE_W] !== 7'h55 ||
            out_dbp[6*PLANE_W +: PLANE_W] !== 7'h7F || out_dbp[6*PLANE_W-1:0] !== '0) begin
            errors++;
            $display("[TB] FAIL short_planes: dbp %h want 2a 55 7f then zeros", out_dbp);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_pingpong_stall();
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j <= 9; j++) begin
                tick(1'b1, j == 9, 1'b0, (j == 0) ? ((b == 0) ? 8'h11 : 8'h22) : {7'(j + 16*b), 1'b0}, 1'b0);
                checks++;
                if ({out_valid, in_ready, error} !== {out_q.size() > 0, out_q.size() < 2, m_err}) begin
                    errors++;
                    $display("[TB] FAIL pp_fill_ctrl: vld/rdy/err got %b%b%b want %b%b%b", out_valid, in_ready, error,
                             out_q.size() > 0, out_q.size() < 2, m_err);
                end
            end
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_base !== 8'h11) begin
            errors++;
            $display("[TB] FAIL pp_stalled: rdy %b vld %b base %h want 0 1 11", in_ready, out_valid, out_base);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (out_q.size() == 0 || {out_base, out_dbp, out_nplanes} !== out_q[0] || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pp_hold: base %h n %0d rdy %b not held", out_base, out_nplanes, in_ready);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_base !== 8'h22 || in_ready !== 1'b1 ||
            out_q.size() == 0 || {out_base, out_dbp, out_nplanes} !== out_q[0]) begin
            errors++;
            $display("[TB] FAIL pp_second: vld %b base %h rdy %b want 1 22 1", out_valid, out_base, in_ready);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pp_drained: vld %b rdy %b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_streaming();
        int pulses = 0;
        int rdy_low = 0;
        for (int b = 0; b < 4; b++) begin
            int n = $urandom_range(0, 9);
            for (int j = 0; j <= n; j++) begin
                tick(1'b1, j == n, 1'b0, 8'($urandom), 1'b1);
                if (out_valid === 1'b1) pulses++;
                if (in_ready !== 1'b1) rdy_low++;
                checks++;
                if (out_q.size() > 0 && {out_base, out_dbp, out_nplanes} !== out_q[0]) begin
                    errors++;
                    $display("[TB] FAIL stream_data: base %h dbp %h n %0d want %h", out_base, out_dbp, out_nplanes, out_q[0]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 4 || rdy_low != 0) begin
            errors++;
            $display("[TB] FAIL stream_flow: pulses %0d rdy_low %0d want 4 0", pulses, rdy_low);
        end
    endtask

    task automatic test_errors();
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        for (int i = 1; i <= 10; i++) tick(1'b1, i == 10, 1'b0, {7'(i), 1'b0}, 1'b0);
        checks++;
        if (error !== 1'b1 || out_valid !== 1'b1 || out_nplanes !== 4'd9 ||
            out_dbp[0 +: PLANE_W] !== 7'h01 || out_dbp[8*PLANE_W +: PLANE_W] !== 7'h09) begin
            errors++;
            $display("[TB] FAIL err_overflow: err %b vld %b n %0d p0 %h p8 %h want 1 1 9 01 09", error, out_valid,
                     out_nplanes, out_dbp[0 +: PLANE_W], out_dbp[8*PLANE_W +: PLANE_W]);
        end
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear1: err got %b want 0", error);
        end
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (error !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_nobase: err %b vld %b want 1 0", error, out_valid);
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: err got %b want 1", error);
        end
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear2: err got %b want 0", error);
        end
    endtask

    task automatic test_clear_reset();
        for (int mode = 0; mode < 2; mode++) begin
            tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
            for (int i = 1; i <= 9; i++) tick(1'b1, i == 9, 1'b0, {7'(i), 1'b0}, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 8'hE0, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 8'hE2, 1'b0);
            if (mode == 0) begin
                tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            end else begin
                push = 1'b0;
                #2 rst_n = 1'b0;
                model_clear();
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            checks++;
            if ({out_valid, in_ready, error} !== 3'b010) begin
                errors++;
                $display("[TB] FAIL clr_state mode %0d: vld/rdy/err got %b%b%b want 010", mode, out_valid, in_ready, error);
            end
            tick(1'b1, 1'b0, 1'b0, 8'h66, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 8'h06, 1'b0);
            tick(1'b1, 1'b1, 1'b0, 8'h08, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_base !== 8'h66 || out_nplanes !== 4'd2 ||
                out_dbp !== {7'h04, 7'h03, 49'd0}) begin
                errors++;
                $display("[TB] FAIL clr_fresh mode %0d: vld %b base %h n %0d dbp %h", mode, out_valid, out_base,
                         out_nplanes, out_dbp);
            end
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0,
                 8'($urandom), $urandom_range(0, 2) != 0);
            checks++;
            if ({out_valid, in_ready, error} !== {out_q.size() > 0, out_q.size() < 2, m_err}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl cyc %0d: vld/rdy/err got %b%b%b want %b%b%b", c, out_valid, in_ready,
                         error, out_q.size() > 0, out_q.size() < 2, m_err);
            end
            if (out_q.size() > 0) begin
                checks++;
                if ({out_base, out_dbp, out_nplanes} !== out_q[0]) begin
                    errors++;
                    $display("[TB] FAIL rand_data cyc %0d: got %h want %h", c, {out_base, out_dbp, out_nplanes}, out_q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_short_block();
        test_pingpong_stall();
        test_streaming();
        test_errors();
        test_clear_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
